alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 32-bit ALU (3-bit alucontrol: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT) between two requesters, e.g. an execute-stage port and a debug/test port.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. The block registers the operands and drives the external ALU, then holds the result until the requester accepts it.

Parameters:
WIDTH, 32, operand/result width
OPW, 3, alucontrol width

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid0  input  1  requester 0 has an operation
req_ready0  output  1  requester 0 operation accepted this cycle
req_valid1  input  1  requester 1 has an operation
req_ready1  output  1  requester 1 operation accepted this cycle
req_op0 / req_op1  input  OPW  alucontrol code per requester
req_a0 / req_a1  input  WIDTH  operand A per requester
req_b0 / req_b1  input  WIDTH  operand B per requester
rsp_valid0  output  1  result ready for requester 0
rsp_valid1  output  1  result ready for requester 1
rsp_ready0 / rsp_ready1  input  1  requester accepts result
rsp_data  output  WIDTH  registered result, shared
rsp_zero  output  1  registered zero flag, shared
alu_srca  output  WIDTH  to ALU srca
alu_srcb  output  WIDTH  to ALU srcb
alu_control  output  OPW  to ALU alucontrol
alu_out  input  WIDTH  from ALU aluout
alu_zero  input  1  from ALU zero

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All req_ready and rsp_valid outputs = 0.
  - rsp_data = 0, rsp_zero = 0.
  - alu_srca, alu_srcb, alu_control = 0.
  - last-grant pointer = 1, so requester 0 wins the first tie.
- State IDLE:
  - Grant the single valid requester. If both are valid, grant the one not equal to the last-grant pointer.
  - req_readyN = (state==IDLE) && grantN. This is combinational from req_valid and is the only cycle ready can be 1.
  - On handshake: capture op/a/b into alu_control/alu_srca/alu_srcb, record granted id and pointer, go to EXEC.
  - With no valid request: stay in IDLE; ALU outputs hold their last values.
- State EXEC (exactly 1 cycle):
  - The ALU sees stable registered inputs.
  - At the clock edge, capture alu_out into rsp_data and alu_zero into rsp_zero, then go to RESP.
- State RESP:
  - rsp_valid of the granted id = 1; the other rsp_valid = 0. rsp_data and rsp_zero are held stable.
  - On rsp_readyN for the granted id, go to IDLE. rsp_ready of the non-granted id is ignored.
- Latency and throughput:
  - Request handshake at edge N gives rsp_valid high from cycle N+2.
  - Minimum 3 cycles per operation.
  - No request is accepted while in EXEC or RESP.
- Requester obligations: payload must be stable while valid and not ready. A requester may drop valid before ready; no capture occurs.
- Both requesters continuously valid: grants alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP): the pending result is discarded, rsp_valid goes to 0 next cycle, and the pointer returns to 1.
- Opcodes 3, 4, 5 pass to the ALU unchanged, so the result is whatever the ALU produces, unless the optional feature is enabled.

Optional Feature:
- Macro ALU_ARB_OPCHECK_EN.
- Enabled:
  - Adds output rsp_err (1 bit, reset 0), registered in EXEC.
  - rsp_err = 1 when the captured op is 3, 4 or 5. rsp_data is then forced to 0 and rsp_zero to 1.
  - rsp_err is valid under the same rsp_valid as the data.
- Disabled: port absent; no opcode filtering.

Decomposition:
- Package alu_arb_pkg holds:
  - localparams OP_AND=3'd0, OP_OR=3'd1, OP_ADD=3'd2, OP_SUB=3'd6, OP_SLT=3'd7.
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - function is_legal_op.
- One natural sub-module, rr_arb2: 2-way round-robin grant logic from valids and the pointer.

Test Plan:
1. Requester 0 only: op=2, a=5, b=7, rsp_ready0=1 → req_ready0 pulses once; two cycles later rsp_valid0=1, rsp_data=12, rsp_zero=0; rsp_valid1 stays 0.
2. Both valid from reset: req0 op=6 a=9 b=9; req1 op=7 a=3 b=4 → req0 granted first (data 0, zero 1); then req1 (data 1, zero 0).
3. Both valid continuously for 4 operations → grant order 0,1,0,1.
4. Backpressure: hold rsp_ready0=0 for 5 cycles with op=0 a=0xF0F0 b=0xFF00 → rsp_valid0 and rsp_data=0xF000 held stable, req_ready1 stays 0 despite req_valid1=1; after rsp_ready0=1, req1 is accepted next cycle.
5. Assert reset during RESP → next cycle all rsp_valid=0, state IDLE; a new simultaneous request grants requester 0.
6. With ALU_ARB_OPCHECK_EN and op=4 a=1 b=1 → rsp_err=1, rsp_data=0, rsp_zero=1; without the macro the port is absent and the run completes.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared opcodes, FSM encoding and opcode legality helper for alu_arbiter
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - 2-way round-robin grant from valids and last-grant pointer
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last,
  output logic grant0,
  output logic grant1
);

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = valid0 && (!valid1 || last);
  assign grant1 = valid1 && (!valid0 || !last);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU; option macro ALU_ARB_OPCHECK_EN
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid0,
  output logic             req_ready0,
  input  logic             req_valid1,
  output logic             req_ready1,
  input  logic [OPW-1:0]   req_op0,
  input  logic [OPW-1:0]   req_op1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ready0,
  input  logic             rsp_ready1,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [OPW-1:0]   alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero
`ifdef ALU_ARB_OPCHECK_EN
  ,
  output logic             rsp_err
`endif
);

  state_t state;
  logic   last_grant;
  logic   gnt_id;
  logic   grant0;
  logic   grant1;

  rr_arb2 u_rr_arb2 (
    .valid0 (req_valid0),
    .valid1 (req_valid1),
    .last   (last_grant),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Ready is only offered while idle, so nothing is accepted during EXEC/RESP.
  assign req_ready0 = (state == IDLE) && grant0;
  assign req_ready1 = (state == IDLE) && grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt_id      <= 1'b0;
      rsp_valid0  <= 1'b0;
      rsp_valid1  <= 1'b0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      alu_srca    <= '0;
      alu_srcb    <= '0;
      alu_control <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_control <= grant1 ? req_op1 : req_op0;
            alu_srca    <= grant1 ? req_a1  : req_a0;
            alu_srcb    <= grant1 ? req_b1  : req_b0;
            gnt_id      <= grant1;
            last_grant  <= grant1;
            state       <= EXEC;
          end
        end
        EXEC: begin
`ifdef ALU_ARB_OPCHECK_EN
          if (!is_legal_op(alu_control)) begin
            rsp_data <= '0;
            rsp_zero <= 1'b1;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_out;
            rsp_zero <= alu_zero;
            rsp_err  <= 1'b0;
          end
`else
          rsp_data <= alu_out;
          rsp_zero <= alu_zero;
`endif
          rsp_valid0 <= !gnt_id;
          rsp_valid1 <= gnt_id;
          state      <= RESP;
        end
        RESP: begin
          // Only the granted requester's rsp_ready can release the result.
          if (gnt_id ? rsp_ready1 : rsp_ready0) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
